// File: rtl/bf_program_loader_pkg.sv
// Shared constants for the BF program loader: opcode encoding, loader error codes, FSM states.
package bf_program_loader_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_HALT  = 4'd0;
  localparam logic [OP_W-1:0] OP_RIGHT = 4'd1;
  localparam logic [OP_W-1:0] OP_LEFT  = 4'd2;
  localparam logic [OP_W-1:0] OP_INC   = 4'd3;
  localparam logic [OP_W-1:0] OP_DEC   = 4'd4;
  localparam logic [OP_W-1:0] OP_OUT   = 4'd5;
  localparam logic [OP_W-1:0] OP_IN    = 4'd6;
  localparam logic [OP_W-1:0] OP_OPEN  = 4'd7;
  localparam logic [OP_W-1:0] OP_CLOSE = 4'd8;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_STRAY    = 2'd1;
  localparam logic [1:0] ERR_UNCLOSED = 2'd2;
  localparam logic [1:0] ERR_PM_FULL  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StSetup,
    StStrobe,
    StFinish,
    StDone,
    StError
  } ld_state_e;

endpackage

// File: rtl/bf_char_decoder.sv
// Combinational ASCII to BF opcode decoder; non-command, non-NUL bytes are comments.
module bf_char_decoder
  import bf_program_loader_pkg::*;
(
  input  logic [7:0]      i_char,
  output logic            o_is_cmd,
  output logic            o_is_nul,
  output logic [OP_W-1:0] o_opcode
);

  always_comb begin
    o_is_cmd = 1'b1;
    o_opcode = OP_HALT;
    case (i_char)
      8'h3e:   o_opcode = OP_RIGHT;
      8'h3c:   o_opcode = OP_LEFT;
      8'h2b:   o_opcode = OP_INC;
      8'h2d:   o_opcode = OP_DEC;
      8'h2e:   o_opcode = OP_OUT;
      8'h2c:   o_opcode = OP_IN;
      8'h5b:   o_opcode = OP_OPEN;
      8'h5d:   o_opcode = OP_CLOSE;
      default: o_is_cmd = 1'b0;
    endcase
  end

  assign o_is_nul = (i_char == 8'h00);

endmodule

// File: rtl/bf_program_loader.sv
// Streams BF source bytes into program memory as opcodes, checks bracket balance, appends HALT.
module bf_program_loader
  import bf_program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH_W = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_load_start,
  input  logic              i_load_end,
  input  logic              i_char_valid,
  input  logic [7:0]        i_char_data,
  output logic              o_char_ready,
  output logic [ADDR_W-1:0] o_pm_addr,
  output logic [OP_W-1:0]   o_pm_data,
  output logic              o_pm_we,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [1:0]        o_err_code,
  output logic [ADDR_W-1:0] o_prog_len
);

  localparam logic [ADDR_W-1:0]  ADDR_MAX  = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  ld_state_e           r_state, w_state;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DEPTH_W-1:0]  r_depth, w_depth;
  logic [OP_W-1:0]     r_op, w_op;
  logic                r_halt, w_halt;
  logic                r_done, w_done;
  logic                r_error, w_error;
  logic [1:0]          r_err_code, w_err_code;
  logic [ADDR_W-1:0]   r_prog_len, w_prog_len;

  logic                w_is_cmd, w_is_nul;
  logic [OP_W-1:0]     w_opcode;

  bf_char_decoder u_dec (
    .i_char   (i_char_data),
    .o_is_cmd (w_is_cmd),
    .o_is_nul (w_is_nul),
    .o_opcode (w_opcode)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_depth    <= '0;
      r_op       <= OP_HALT;
      r_halt     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
      r_prog_len <= '0;
    end else begin
      r_state    <= w_state;
      r_addr     <= w_addr;
      r_depth    <= w_depth;
      r_op       <= w_op;
      r_halt     <= w_halt;
      r_done     <= w_done;
      r_error    <= w_error;
      r_err_code <= w_err_code;
      r_prog_len <= w_prog_len;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_addr     = r_addr;
    w_depth    = r_depth;
    w_op       = r_op;
    w_halt     = r_halt;
    w_done     = r_done;
    w_error    = r_error;
    w_err_code = r_err_code;
    w_prog_len = r_prog_len;
    unique case (r_state)
      StIdle, StDone, StError: begin
        if (i_load_start) begin
          w_state    = StAccept;
          w_addr     = '0;
          w_depth    = '0;
          w_done     = 1'b0;
          w_error    = 1'b0;
          w_err_code = ERR_NONE;
          w_prog_len = '0;
        end
      end
      StAccept: begin
        // load_end has priority; a same-cycle byte is not taken (char_ready is low).
        if (i_load_end) begin
          w_state = StFinish;
        end else if (i_char_valid && w_is_nul) begin
          w_state = StFinish;
        end else if (i_char_valid && w_is_cmd) begin
          if (r_addr == ADDR_MAX) begin
            w_state    = StError;
            w_error    = 1'b1;
            w_err_code = ERR_PM_FULL;
          end else if (w_opcode == OP_CLOSE && r_depth == '0) begin
            w_state    = StError;
            w_error    = 1'b1;
            w_err_code = ERR_STRAY;
          end else if (w_opcode == OP_OPEN && r_depth == DEPTH_MAX) begin
            w_state    = StError;
            w_error    = 1'b1;
            w_err_code = ERR_UNCLOSED;
          end else begin
            w_state = StSetup;
            w_op    = w_opcode;
            w_halt  = 1'b0;
            if (w_opcode == OP_OPEN) w_depth = r_depth + DEPTH_W'(1);
            if (w_opcode == OP_CLOSE) w_depth = r_depth - DEPTH_W'(1);
          end
        end
      end
      StSetup: w_state = StStrobe;
      StStrobe: begin
        if (r_halt) begin
          w_state    = StDone;
          w_done     = 1'b1;
          w_prog_len = r_addr;
        end else begin
          w_state = StAccept;
          w_addr  = r_addr + ADDR_W'(1);
        end
      end
      StFinish: begin
        if (r_depth != '0) begin
          w_state    = StError;
          w_error    = 1'b1;
          w_err_code = ERR_UNCLOSED;
        end else begin
          w_state = StSetup;
          w_op    = OP_HALT;
          w_halt  = 1'b1;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  assign o_char_ready = (r_state == StAccept) && !i_load_end;
  assign o_pm_addr    = r_addr;
  assign o_pm_data    = r_op;
  assign o_pm_we      = (r_state == StStrobe);
  assign o_busy       = (r_state == StAccept) || (r_state == StSetup) ||
                        (r_state == StStrobe) || (r_state == StFinish);
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_err_code   = r_err_code;
  assign o_prog_len   = r_prog_len;

endmodule

// File: tb/tb_bf_program_loader.sv
// Directed bench for bf_program_loader: table of source programs plus hand-written corner cases.
module tb_bf_program_loader;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          load_end = 1'b0;
  logic          char_valid = 1'b0;
  logic [7:0]    char_data = 8'h00;
  logic          char_ready;
  logic [AW-1:0] pm_addr;
  logic [3:0]    pm_data;
  logic          pm_we;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [AW-1:0] prog_len;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] pm [16];
  int         wr_cnt = 0;

  always #5 clk = ~clk;

  bf_program_loader #(.ADDR_W(AW), .DEPTH_W(DW)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_load_start (load_start),
    .i_load_end   (load_end),
    .i_char_valid (char_valid),
    .i_char_data  (char_data),
    .o_char_ready (char_ready),
    .o_pm_addr    (pm_addr),
    .o_pm_data    (pm_data),
    .o_pm_we      (pm_we),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_err_code   (err_code),
    .o_prog_len   (prog_len)
  );

  // Program memory model: a write happens on each clock edge where the strobe is high.
  always @(posedge clk) begin
    if (pm_we === 1'b1) begin
      pm[pm_addr] <= pm_data;
      wr_cnt      <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic [159:0] src;
    int           len;
    int           end_kind;   // 0 none, 1 load_end pulse, 2 trailing NUL byte
    bit           exp_err;
    logic [1:0]   exp_code;
    logic [63:0]  exp_pm;     // nibble i is the opcode expected at PM[i]
    int           exp_writes;
    int           exp_len;
    int           exp_waits;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic [159:0] src, input int len, input int end_kind,
                              input bit exp_err, input logic [1:0] exp_code,
                              input logic [63:0] exp_pm, input int exp_writes,
                              input int exp_len, input int exp_waits);
    vec_t v;
    v.src = src; v.len = len; v.end_kind = end_kind; v.exp_err = exp_err;
    v.exp_code = exp_code; v.exp_pm = exp_pm; v.exp_writes = exp_writes;
    v.exp_len = exp_len; v.exp_waits = exp_waits;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int c;
    c = 0;
    @(negedge clk);
    while (!char_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!char_ready) chk({name, " ready timeout"}, 64'(char_ready), 64'd1);
  endtask

  task automatic send(input logic [7:0] b, output int waits);
    waits = 0;
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = b;
    while (!char_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!char_ready) chk("send ready timeout", 64'(char_ready), 64'd1);
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic pulse_end();
    wait_ready("load_end");
    load_end = 1'b1;
    @(posedge clk);
    #1 load_end = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    int c;
    c = 0;
    @(negedge clk);
    while (!(done || error) && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (!(done || error)) chk({name, " finish timeout"}, 64'(done | error), 64'd1);
  endtask

  initial begin
    int w, tw, base;
    logic [7:0] b;
    logic       seen;
    int         c;

    repeat (2) @(negedge clk);
    chk("reset outputs", 64'({char_ready, pm_addr, pm_data, pm_we, busy, done, error,
                              err_code, prog_len}), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;

    vecs[0] = mk(160'("+>."), 3, 1, 0, 2'd0, 64'h0513, 4, 3, 4);
    vecs[1] = mk(160'("a+ b\n-"), 6, 2, 0, 2'd0, 64'h043, 3, 2, 4);
    vecs[2] = mk(160'("[[-]]"), 5, 2, 0, 2'd0, 64'h088477, 6, 5, 10);
    vecs[3] = mk(160'("+]"), 2, 0, 1, 2'd1, 64'h3, 1, 0, 2);
    vecs[4] = mk(160'("[+"), 2, 1, 1, 2'd2, 64'h37, 2, 0, 2);
    vecs[5] = mk(160'("[[[["), 4, 0, 1, 2'd2, 64'h777, 3, 0, 6);
    vecs[6] = mk(160'("++++++++++++++++"), 16, 0, 1, 2'd3, 64'h0333_3333_3333_3333, 15, 0, 30);
    vecs[7] = mk(160'("+++++++++++++++"), 15, 2, 0, 2'd0, 64'h0333_3333_3333_3333, 16, 15, 30);

    for (int i = 0; i < 8; i++) begin
      base = wr_cnt;
      tw   = 0;
      pulse_start();
      for (int j = 0; j < vecs[i].len; j++) begin
        b = vecs[i].src[8*(vecs[i].len-1-j) +: 8];
        send(b, w);
        tw += w;
      end
      if (vecs[i].end_kind == 1) pulse_end();
      else if (vecs[i].end_kind == 2) begin
        send(8'h00, w);
        tw += w;
      end
      wait_finish($sformatf("v%0d", i));
      chk($sformatf("v%0d done", i), 64'(done), 64'(!vecs[i].exp_err));
      chk($sformatf("v%0d error", i), 64'(error), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d err_code", i), 64'(err_code), 64'(vecs[i].exp_code));
      chk($sformatf("v%0d prog_len", i), 64'(prog_len), 64'(vecs[i].exp_len));
      chk($sformatf("v%0d writes", i), 64'(wr_cnt - base), 64'(vecs[i].exp_writes));
      chk($sformatf("v%0d wait cycles", i), 64'(tw), 64'(vecs[i].exp_waits));
      chk($sformatf("v%0d busy", i), 64'(busy), 64'd0);
      for (int j = 0; j < vecs[i].exp_writes; j++)
        chk($sformatf("v%0d pm[%0d]", i, j), 64'(pm[j]), 64'(vecs[i].exp_pm[4*j +: 4]));
    end

    // busy drops the cycle after the HALT strobe
    pulse_start();
    send(8'h2e, w);
    pulse_end();
    seen = 1'b0;
    c = 0;
    while (!seen && c < 20) begin
      @(negedge clk);
      c++;
      if (pm_we && pm_data == 4'd0) seen = 1'b1;
    end
    chk("halt strobe seen", 64'(seen), 64'd1);
    chk("halt strobe addr", 64'(pm_addr), 64'd1);
    chk("busy during halt strobe", 64'(busy), 64'd1);
    @(negedge clk);
    chk("busy after halt strobe", 64'(busy), 64'd0);
    chk("done after halt strobe", 64'(done), 64'd1);

    // load_end together with a valid byte: byte refused, only HALT written
    base = wr_cnt;
    pulse_start();
    wait_ready("same-cycle");
    char_valid = 1'b1;
    char_data  = 8'h2b;
    load_end   = 1'b1;
    #1 chk("ready with load_end", 64'(char_ready), 64'd0);
    @(posedge clk);
    #1 begin
      char_valid = 1'b0;
      load_end   = 1'b0;
    end
    wait_finish("same-cycle");
    chk("same-cycle done", 64'(done), 64'd1);
    chk("same-cycle writes", 64'(wr_cnt - base), 64'd1);
    chk("same-cycle prog_len", 64'(prog_len), 64'd0);
    chk("same-cycle pm[0]", 64'(pm[0]), 64'd0);

    // Asynchronous reset in the middle of a strobe
    pulse_start();
    send(8'h2b, w);
    c = 0;
    @(negedge clk);
    while (!pm_we && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("strobe before reset", 64'(pm_we), 64'd1);
    rst = 1'b1;
    #1 chk("async reset outputs", 64'({char_ready, pm_addr, pm_data, pm_we, busy, done, error,
                                       err_code, prog_len}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    base = wr_cnt;
    pulse_start();
    send(8'h2e, w);
    pulse_end();
    wait_finish("post-reset");
    chk("post-reset done", 64'(done), 64'd1);
    chk("post-reset writes", 64'(wr_cnt - base), 64'd2);
    chk("post-reset pm[0]", 64'(pm[0]), 64'd5);
    chk("post-reset pm[1]", 64'(pm[1]), 64'd0);
    chk("post-reset prog_len", 64'(prog_len), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
